// File: rtl/adder_result_checker.sv
// Checks a pipelined 8-bit adder: each issued operand pair is summed here, delayed by
// LATENCY cycles and compared against the adder's result, with tallies and first-error capture.
module adder_result_checker #(
    parameter int          LATENCY      = 1,
    parameter int unsigned EXPECTED_LEN = 2000000
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        valid_i,
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    input  logic [7:0]  res_i,
    input  logic        clear_i,
    output logic [31:0] match_cnt_o,
    output logic [31:0] mismatch_cnt_o,
    output logic [31:0] first_err_idx_o,
    output logic [7:0]  first_err_exp_o,
    output logic [7:0]  first_err_got_o,
    output logic        err_o,
    output logic        done_o,
    output logic        dbg_state_o
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    localparam logic [31:0] LAST_IDX = 32'(EXPECTED_LEN - 1);
    localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

    state_e             state_q, state_d;
    logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [7:0]         pipe_exp_q [LATENCY];
    logic [7:0]         pipe_exp_d [LATENCY];
    logic [31:0]        match_cnt_q, match_cnt_d;
    logic [31:0]        mismatch_cnt_q, mismatch_cnt_d;
    logic [31:0]        idx_q, idx_d;
    logic [31:0]        first_idx_q, first_idx_d;
    logic [7:0]         first_exp_q, first_exp_d;
    logic [7:0]         first_got_q, first_got_d;
    logic               err_q, err_d;

    logic               issue;
    logic               cmp_en;
    logic               cmp_ok;
    logic [7:0]         cmp_exp;

    // Issue and compare are both suppressed while DONE and during a clear.
    always_comb begin
        issue   = valid_i && (state_q == ST_RUN) && !clear_i;
        cmp_exp = pipe_exp_q[LATENCY-1];
        cmp_en  = pipe_vld_q[LATENCY-1] && (state_q == ST_RUN) && !clear_i;
        cmp_ok  = (res_i == cmp_exp);
    end

    always_comb begin
        pipe_vld_d = pipe_vld_q;
        for (int i = 0; i < LATENCY; i++) begin
            pipe_exp_d[i] = pipe_exp_q[i];
        end
        pipe_vld_d[0] = issue;
        pipe_exp_d[0] = a_i + b_i;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_exp_d[i] = pipe_exp_q[i-1];
        end
        if (clear_i) begin
            pipe_vld_d = '0;
        end
    end

    always_comb begin
        state_d        = state_q;
        match_cnt_d    = match_cnt_q;
        mismatch_cnt_d = mismatch_cnt_q;
        idx_d          = idx_q;
        first_idx_d    = first_idx_q;
        first_exp_d    = first_exp_q;
        first_got_d    = first_got_q;
        err_d          = err_q;

        if (clear_i) begin
            state_d        = ST_RUN;
            match_cnt_d    = '0;
            mismatch_cnt_d = '0;
            idx_d          = '0;
            first_idx_d    = '0;
            first_exp_d    = '0;
            first_got_d    = '0;
            err_d          = 1'b0;
        end else if (cmp_en) begin
            if (cmp_ok) begin
                if (match_cnt_q != CNT_MAX) begin
                    match_cnt_d = match_cnt_q + 32'd1;
                end
            end else begin
                if (mismatch_cnt_q != CNT_MAX) begin
                    mismatch_cnt_d = mismatch_cnt_q + 32'd1;
                end
                // Only the first mismatch of a run is captured.
                if (!err_q) begin
                    err_d       = 1'b1;
                    first_idx_d = idx_q;
                    first_exp_d = cmp_exp;
                    first_got_d = res_i;
                end
            end
            idx_d = idx_q + 32'd1;
            if (idx_q == LAST_IDX) begin
                state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q        <= ST_RUN;
            pipe_vld_q     <= '0;
            match_cnt_q    <= '0;
            mismatch_cnt_q <= '0;
            idx_q          <= '0;
            first_idx_q    <= '0;
            first_exp_q    <= '0;
            first_got_q    <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            pipe_vld_q     <= pipe_vld_d;
            match_cnt_q    <= match_cnt_d;
            mismatch_cnt_q <= mismatch_cnt_d;
            idx_q          <= idx_d;
            first_idx_q    <= first_idx_d;
            first_exp_q    <= first_exp_d;
            first_got_q    <= first_got_d;
            err_q          <= err_d;
        end
    end

    // Expected values are qualified by pipe_vld_q, so they need no reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < LATENCY; i++) begin
            pipe_exp_q[i] <= pipe_exp_d[i];
        end
    end

    assign match_cnt_o     = match_cnt_q;
    assign mismatch_cnt_o  = mismatch_cnt_q;
    assign first_err_idx_o = first_idx_q;
    assign first_err_exp_o = first_exp_q;
    assign first_err_got_o = first_got_q;
    assign err_o           = err_q;
    assign done_o          = (state_q == ST_DONE);
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_adder_result_checker.sv
// Bench for adder_result_checker: three instances (LATENCY 1/2/3) against a
// due-time queue model, plus directed scenarios with literal expectations.
module tb_adder_result_checker;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vld [3];
    logic        clr [3];
    logic [7:0]  a   [3];
    logic [7:0]  b   [3];
    logic [7:0]  res [3];
    logic [31:0] mc  [3];
    logic [31:0] mm  [3];
    logic [31:0] fi  [3];
    logic [7:0]  fe  [3];
    logic [7:0]  fg  [3];
    logic        er  [3];
    logic        dn  [3];
    logic        st  [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Scheduled adder results per instance, indexed by edge number mod 16.
    logic [8:0]  rs [3][16];

    logic [31:0] m_mc [3];
    logic [31:0] m_mm [3];
    logic [31:0] m_idx[3];
    logic [31:0] m_fi [3];
    logic [7:0]  m_fe [3];
    logic [7:0]  m_fg [3];
    logic        m_err[3];
    logic        m_done[3];
    logic [39:0] pend [3][$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        adder_result_checker #(
            .LATENCY     (g + 1),
            .EXPECTED_LEN((g == 0) ? 4 : ((g == 1) ? 3 : 1000))
        ) u_dut (
            .clk_i          (clk),
            .reset_ni       (reset_n),
            .valid_i        (vld[g]),
            .a_i            (a[g]),
            .b_i            (b[g]),
            .res_i          (res[g]),
            .clear_i        (clr[g]),
            .match_cnt_o    (mc[g]),
            .mismatch_cnt_o (mm[g]),
            .first_err_idx_o(fi[g]),
            .first_err_exp_o(fe[g]),
            .first_err_got_o(fg[g]),
            .err_o          (er[g]),
            .done_o         (dn[g]),
            .dbg_state_o    (st[g])
        );
    end

    function automatic int lat(input int k);
        return k + 1;
    endfunction

    function automatic int elen(input int k);
        case (k)
            0:       return 4;
            1:       return 3;
            default: return 1000;
        endcase
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0d expected=%0d", name, k, cyc, got, exp);
        end
    endtask

    task automatic model_step(input int k);
        logic [39:0] ent;
        logic [7:0]  s;
        logic        was_done;
        was_done = m_done[k];
        if (!reset_n || clr[k]) begin
            m_mc[k] = '0; m_mm[k] = '0; m_idx[k] = '0; m_fi[k] = '0;
            m_fe[k] = '0; m_fg[k] = '0; m_err[k] = 1'b0; m_done[k] = 1'b0;
            pend[k].delete();
        end else begin
            if (pend[k].size() > 0) begin
                ent = pend[k][0];
                if (ent[39:8] == 32'(cyc)) begin
                    void'(pend[k].pop_front());
                    if (!was_done) begin
                        if (res[k] == ent[7:0]) begin
                            if (m_mc[k] != 32'hFFFF_FFFF) m_mc[k] = m_mc[k] + 1;
                        end else begin
                            if (m_mm[k] != 32'hFFFF_FFFF) m_mm[k] = m_mm[k] + 1;
                            if (!m_err[k]) begin
                                m_err[k] = 1'b1;
                                m_fi[k]  = m_idx[k];
                                m_fe[k]  = ent[7:0];
                                m_fg[k]  = res[k];
                            end
                        end
                        if (m_idx[k] == 32'(elen(k) - 1)) m_done[k] = 1'b1;
                        m_idx[k] = m_idx[k] + 1;
                    end
                end
            end
            if (!was_done && vld[k]) begin
                s = a[k] + b[k];
                pend[k].push_back({32'(cyc + lat(k)), s});
            end
        end
    endtask

    // Model advances on every edge; outputs are compared 1 time unit later.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) model_step(k);
        cyc = cyc + 1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("match_cnt",     k, mc[k], m_mc[k]);
            chk("mismatch_cnt",  k, mm[k], m_mm[k]);
            chk("first_err_idx", k, fi[k], m_fi[k]);
            chk("first_err_exp", k, 32'(fe[k]), 32'(m_fe[k]));
            chk("first_err_got", k, 32'(fg[k]), 32'(m_fg[k]));
            chk("err",           k, 32'(er[k]), 32'(m_err[k]));
            chk("done",          k, 32'(dn[k]), 32'(m_done[k]));
            chk("state",         k, 32'(st[k]), 32'(m_done[k]));
        end
    end

    task automatic issue(input int k, input logic [7:0] x, input logic [7:0] y, input logic [7:0] r);
        vld[k] = 1'b1;
        a[k]   = x;
        b[k]   = y;
        rs[k][(cyc + lat(k)) % 16] = {1'b1, r};
    endtask

    task automatic issue_ok(input int k, input logic [7:0] x, input logic [7:0] y);
        logic [7:0] s;
        s = x + y;
        issue(k, x, y, s);
    endtask

    task automatic tick();
        for (int k = 0; k < 3; k++) begin
            if (rs[k][cyc % 16][8]) res[k] = rs[k][cyc % 16][7:0];
            else                    res[k] = 8'($urandom);
            rs[k][cyc % 16] = 9'd0;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            vld[k] = 1'b0;
            clr[k] = 1'b0;
            a[k]   = 8'($urandom);
            b[k]   = 8'($urandom);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] r;
        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vld[k] = 1'b0; clr[k] = 1'b0; a[k] = '0; b[k] = '0; res[k] = '0;
            m_done[k] = 1'b0;
            for (int j = 0; j < 16; j++) rs[k][j] = 9'd0;
        end
        repeat (3) tick();
        chk("reset_match", 0, mc[0], 32'd0);
        chk("reset_done",  0, 32'(dn[0]), 32'd0);
        reset_n = 1'b1;

        // Four correct results at LATENCY 1, including carry wrap.
        issue(0, 8'd1, 8'd2, 8'd3);     tick();
        issue(0, 8'd200, 8'd100, 8'd44); tick();
        issue(0, 8'd255, 8'd1, 8'd0);   tick();
        issue(0, 8'd0, 8'd0, 8'd0);     tick();
        chk("l1_match_before_last", 0, mc[0], 32'd3);
        chk("l1_done_before_last",  0, 32'(dn[0]), 32'd0);
        tick();
        chk("l1_match", 0, mc[0], 32'd4);
        chk("l1_mismatch", 0, mm[0], 32'd0);
        chk("l1_err", 0, 32'(er[0]), 32'd0);
        chk("l1_done", 0, 32'(dn[0]), 32'd1);

        // DONE ignores new traffic; clear restarts and discards same-cycle work.
        repeat (3) begin issue(0, 8'd1, 8'd1, 8'd99); tick(); end
        tick();
        chk("done_hold_match", 0, mc[0], 32'd4);
        chk("done_hold_mismatch", 0, mm[0], 32'd0);
        clr[0] = 1'b1; tick();
        chk("clear_match", 0, mc[0], 32'd0);
        chk("clear_done", 0, 32'(dn[0]), 32'd0);
        issue(0, 8'd2, 8'd2, 8'd5); tick();
        clr[0] = 1'b1; issue(0, 8'd9, 8'd9, 8'd1); tick();
        tick(); tick();
        chk("clear_discard_mismatch", 0, mm[0], 32'd0);
        chk("clear_discard_match", 0, mc[0], 32'd0);
        for (int i = 0; i < 4; i++) begin issue_ok(0, 8'(i * 3), 8'(i * 7)); tick(); end
        tick();
        chk("rerun_match", 0, mc[0], 32'd4);
        chk("rerun_done", 0, 32'(dn[0]), 32'd1);

        // LATENCY 2: one mismatch at index 1.
        issue(1, 8'd5, 8'd5, 8'd10); tick();
        issue(1, 8'd7, 8'd1, 8'd9);  tick();
        issue(1, 8'd9, 8'd9, 8'd18); tick();
        tick(); tick();
        chk("l2_mismatch", 1, mm[1], 32'd1);
        chk("l2_match", 1, mc[1], 32'd2);
        chk("l2_idx", 1, fi[1], 32'd1);
        chk("l2_exp", 1, 32'(fe[1]), 32'd8);
        chk("l2_got", 1, 32'(fg[1]), 32'd9);
        chk("l2_err", 1, 32'(er[1]), 32'd1);
        chk("l2_done", 1, 32'(dn[1]), 32'd1);

        // Two mismatches: capture keeps the first.
        clr[1] = 1'b1; tick();
        issue(1, 8'd1, 8'd2, 8'd4);    tick();
        issue(1, 8'd3, 8'd3, 8'd6);    tick();
        issue(1, 8'd10, 8'd10, 8'd0);  tick();
        tick(); tick();
        chk("two_err_mismatch", 1, mm[1], 32'd2);
        chk("two_err_idx", 1, fi[1], 32'd0);
        chk("two_err_exp", 1, 32'(fe[1]), 32'd3);
        chk("two_err_got", 1, 32'(fg[1]), 32'd4);

        // LATENCY 3: reset lands before the results arrive.
        issue_ok(2, 8'd11, 8'd22); tick();
        issue_ok(2, 8'd33, 8'd44); tick();
        reset_n = 1'b0; tick();
        reset_n = 1'b1;
        repeat (5) tick();
        chk("rst_inflight_match", 2, mc[2], 32'd0);
        chk("rst_inflight_mismatch", 2, mm[2], 32'd0);
        chk("rst_other_match", 0, mc[0], 32'd0);
        chk("rst_other_err", 1, 32'(er[1]), 32'd0);

        // 1000 correct pairs, mostly back-to-back with idle gaps.
        n = 0;
        while (n < 1000) begin
            issue_ok(2, 8'($urandom), 8'($urandom)); tick();
            n++;
            if ($urandom_range(0, 19) == 0) repeat ($urandom_range(1, 3)) tick();
        end
        repeat (4) tick();
        chk("long_match", 2, mc[2], 32'd1000);
        chk("long_mismatch", 2, mm[2], 32'd0);
        chk("long_done", 2, 32'(dn[2]), 32'd1);

        // Random traffic, corruption, clears and resets against the model.
        repeat (3000) begin
            reset_n = ($urandom_range(0, 499) != 0);
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 49) == 0) clr[k] = 1'b1;
                if ($urandom_range(0, 3) != 0) begin
                    a[k] = 8'($urandom);
                    b[k] = 8'($urandom);
                    r = a[k] + b[k];
                    if ($urandom_range(0, 7) == 0) r = r ^ 8'($urandom_range(1, 255));
                    issue(k, a[k], b[k], r);
                end
            end
            tick();
        end
        reset_n = 1'b1;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_result_checker.md
ADDER_RESULT_CHECKER -- requirements
Module: adder_result_checker

Interface
REQ-001 The block SHALL have parameter LATENCY, default 1, meaning cycles from operand issue to the adder result (legal 1..8).
REQ-002 The block SHALL have parameter EXPECTED_LEN, default 2000000, meaning number of results to check before completion (legal 1..2^32-1).
REQ-003 The block SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_ni  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port valid_i  input  1  operand pair issued to the adder this cycle.
REQ-006 The block SHALL have ports a_i and b_i  input  8 each  operands issued with valid_i.
REQ-007 The block SHALL have port res_i  input  8  adder result, valid LATENCY cycles after the matching issue.
REQ-008 The block SHALL have port clear_i  input  1  synchronous restart of a check run.
REQ-009 The block SHALL have ports match_cnt_o and mismatch_cnt_o  output  32 each  compare tallies.
REQ-010 The block SHALL have port first_err_idx_o  output  32  index of the first mismatching result.
REQ-011 The block SHALL have ports first_err_exp_o and first_err_got_o  output  8 each  expected and received values at the first mismatch.
REQ-012 The block SHALL have ports err_o and done_o  output  1 each  sticky mismatch flag; run complete.

Function
REQ-013 Expected value SHALL be (a_i + b_i) mod 256, computed at issue; carry discarded.
REQ-014 The block SHALL delay {valid_i, expected} through a LATENCY-deep shift register, so an entry issued in cycle t is compared against res_i in cycle t+LATENCY.
REQ-015 A compare SHALL occur only when the delayed valid bit is 1 and state is RUN; res_i SHALL be ignored otherwise.
REQ-016 Each compare SHALL increment match_cnt_o if res_i equals expected, otherwise mismatch_cnt_o, both saturating at 2^32-1.
REQ-017 An index counter SHALL count compares from 0; the compare's index is the counter value before increment.
REQ-018 On the first mismatch since reset/clear, first_err_idx_o/exp/got SHALL capture index, expected and res_i, and err_o SHALL set; later mismatches SHALL NOT overwrite them.
REQ-019 FSM states SHALL be RUN and DONE; RUN -> DONE on the cycle the compare with index EXPECTED_LEN-1 completes; DONE -> RUN only on clear_i or reset.
REQ-020 In DONE, done_o SHALL be 1, counters and capture registers SHALL hold, and the pipeline SHALL ignore valid_i.
REQ-021 Outputs SHALL be registered; counter and flag updates SHALL be visible the cycle after the compare.
REQ-022 clear_i=1 SHALL zero counters, capture registers, err_o, done_o and the index, flush all pipeline valid bits, and enter RUN; a compare due in that same cycle SHALL be discarded.
REQ-023 valid_i in the same cycle as clear_i SHALL be dropped.
REQ-024 Back-to-back valid_i every cycle SHALL be supported with no lost compares.

Reset
REQ-025 reset_ni=0 at a rising edge SHALL produce the same state as clear_i=1, with all outputs 0 and state RUN.
REQ-026 Reset SHALL take priority over clear_i and any compare, and SHALL discard all in-flight pipeline entries.
REQ-027 The first valid_i accepted is the one sampled on the first edge with reset_ni=1.

Verification
REQ-028 LATENCY=1, EXPECTED_LEN=4, pairs (1,2)(200,100)(255,1)(0,0), res 3,44,0,0 -> match_cnt_o=4, mismatch_cnt_o=0, err_o=0, done_o=1 one cycle after last compare.
REQ-029 LATENCY=2, EXPECTED_LEN=3, pairs (5,5)(7,1)(9,9), res 10,9,18 -> mismatch_cnt_o=1, first_err_idx_o=1, first_err_exp_o=8, first_err_got_o=9, err_o=1.
REQ-030 Two mismatches at index 0 (exp 3, got 4) and index 2 -> capture keeps idx 0/3/4, mismatch_cnt_o=2.
REQ-031 LATENCY=3, issue 2 pairs, assert reset_ni=0 before their results arrive, release -> no compares counted, all outputs 0.
REQ-032 In DONE, further valid_i with wrong res_i -> counters unchanged; then clear_i=1 -> all outputs 0, new run checks normally.
REQ-033 valid_i every cycle for 1000 pairs with gaps of idle cycles inserted, all correct, EXPECTED_LEN=1000 -> match_cnt_o=1000, done_o=1.
